// File: rtl/epd_pkg.sv
// Shared types and limits for the epd Ethernet packet detector.
// Optional feature: define EPD_JUMBO_EN to accept jumbo frames (MAX_FRAME 9018,
// 14-bit size counter); otherwise MAX_FRAME is 1518 with an 11-bit counter.
package epd_pkg;

    // Parser states: hunt, preamble, destination, source, type/length, payload
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DST  = 3'd2,
        S_SRC  = 3'd3,
        S_TYPE = 3'd4,
        S_DATA = 3'd5
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          MIN_FRAME     = 64;
    localparam logic [15:0] LEN_MAX       = 16'd1500;
    localparam logic [15:0] TYPE_MIN      = 16'h0600;

`ifdef EPD_JUMBO_EN
    localparam int MAX_FRAME = 9018;
    localparam int SIZE_W    = 14;
`else
    localparam int MAX_FRAME = 1518;
    localparam int SIZE_W    = 11;
`endif

    // Type/length field is legal as an 802.3 length or as an EtherType
    function automatic logic type_length_ok(input logic [15:0] tl);
        return (tl <= LEN_MAX) || (tl >= TYPE_MIN);
    endfunction

endpackage

// File: rtl/epd_size_counter.sv
// Saturating frame-size counter with a combinational in-range flag.
// Width and limits come from epd_pkg (EPD_JUMBO_EN selects the jumbo limits).
module epd_size_counter
    import epd_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic in_range
);

    localparam logic [SIZE_W-1:0] SIZE_SAT = '1;
    localparam logic [SIZE_W-1:0] MIN_W    = SIZE_W'(MIN_FRAME);
    localparam logic [SIZE_W-1:0] MAX_W    = SIZE_W'(MAX_FRAME);

    logic [SIZE_W-1:0] size;

    // Count data bytes; clear wins; hold at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            size <= '0;
        end else if (clear) begin
            size <= '0;
        end else if (inc && (size != SIZE_SAT)) begin
            size <= size + 1'b1;
        end
    end

    // Size acceptable for a complete frame
    always_comb begin
        in_range = (size >= MIN_W) && (size <= MAX_W);
    end

endmodule

// File: rtl/epd.sv
// epd: Ethernet packet detector on an XGMII-style byte stream.
// Parses preamble/SFD, destination, source and type/length fields, checks the
// frame size at termination and counts frames that pass every check.
// Optional feature: EPD_JUMBO_EN (see epd_pkg) raises the frame size limit.
// Stream contract: one byte per clock, no back-pressure; control=1 marks
// IFG/terminate characters and ends or aborts a frame in progress.
module epd
    import epd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       control,
    output logic       preamble_valid,
    output logic       dst_addr_valid,
    output logic       src_addr_valid,
    output logic       type_length_valid,
    output logic       packet_size_valid,
    output logic [3:0] valid_packet_counter
);

    state_t state;
    state_t next_state;

    logic [2:0]  pre_cnt;
    logic [2:0]  field_cnt;
    logic [47:0] dst_addr;
    logic [39:0] src_addr;
    logic [7:0]  type_hi;

    logic pre_start;
    logic pre_inc;
    logic sfd_ok;
    logic dst_done;
    logic src_done;
    logic type_done;
    logic terminate;
    logic field_shift;
    logic count_byte;
    logic size_ok;

    logic [47:0] dst_next;
    logic [47:0] src_next;
    logic [15:0] tl_next;

    assign dst_next = {dst_addr[39:0], data};
    assign src_next = {src_addr, data};
    assign tl_next  = {type_hi, data};

    // Header bytes advance the per-field byte index; every frame data byte
    // from the first destination byte onward counts toward the frame size
    assign field_shift = !control &&
                         ((state == S_DST) || (state == S_SRC) || (state == S_TYPE));
    assign count_byte  = !control &&
                         ((state == S_DST) || (state == S_SRC) ||
                          (state == S_TYPE) || (state == S_DATA));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and one-cycle event strobes for the datapath
    always_comb begin
        next_state = state;
        pre_start  = 1'b0;
        pre_inc    = 1'b0;
        sfd_ok     = 1'b0;
        dst_done   = 1'b0;
        src_done   = 1'b0;
        type_done  = 1'b0;
        terminate  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!control && (data == PREAMBLE_BYTE)) begin
                    pre_start  = 1'b1;
                    next_state = S_PRE;
                end
            end
            S_PRE: begin
                if (control) begin
                    next_state = S_IDLE;
                end else if (data == PREAMBLE_BYTE) begin
                    // An eighth preamble byte is a malformed preamble
                    if (pre_cnt == 3'(PREAMBLE_LEN)) begin
                        next_state = S_IDLE;
                    end else begin
                        pre_inc = 1'b1;
                    end
                end else if ((data == SFD_BYTE) && (pre_cnt == 3'(PREAMBLE_LEN))) begin
                    sfd_ok     = 1'b1;
                    next_state = S_DST;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_DST: begin
                if (control) begin
                    next_state = S_IDLE;
                end else if (field_cnt == 3'd5) begin
                    dst_done   = 1'b1;
                    next_state = S_SRC;
                end
            end
            S_SRC: begin
                if (control) begin
                    next_state = S_IDLE;
                end else if (field_cnt == 3'd5) begin
                    src_done   = 1'b1;
                    next_state = S_TYPE;
                end
            end
            S_TYPE: begin
                if (control) begin
                    next_state = S_IDLE;
                end else if (field_cnt == 3'd1) begin
                    type_done  = 1'b1;
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (control) begin
                    terminate  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Preamble byte count, starting at 1 on the byte that opens the frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_start) begin
            pre_cnt <= 3'd1;
        end else if (pre_inc) begin
            pre_cnt <= pre_cnt + 3'd1;
        end
    end

    // Byte index within the current header field
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            field_cnt <= '0;
        end else if (sfd_ok || dst_done || src_done || type_done) begin
            field_cnt <= '0;
        end else if (field_shift) begin
            field_cnt <= field_cnt + 3'd1;
        end
    end

    // Header field capture, MSB first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dst_addr <= '0;
            src_addr <= '0;
            type_hi  <= '0;
        end else begin
            if (!control && (state == S_DST)) begin
                dst_addr <= dst_next;
            end
            if (!control && (state == S_SRC)) begin
                src_addr <= src_next[39:0];
            end
            if (!control && (state == S_TYPE)) begin
                type_hi <= data;
            end
        end
    end

    // Sticky field flags: cleared when a new preamble starts, each set as its
    // field completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            preamble_valid    <= 1'b0;
            dst_addr_valid    <= 1'b0;
            src_addr_valid    <= 1'b0;
            type_length_valid <= 1'b0;
            packet_size_valid <= 1'b0;
        end else if (pre_start) begin
            preamble_valid    <= 1'b0;
            dst_addr_valid    <= 1'b0;
            src_addr_valid    <= 1'b0;
            type_length_valid <= 1'b0;
            packet_size_valid <= 1'b0;
        end else begin
            if (sfd_ok) begin
                preamble_valid <= 1'b1;
            end
            if (dst_done) begin
                dst_addr_valid <= (dst_next != 48'd0);
            end
            if (src_done) begin
                src_addr_valid <= (src_next != 48'd0) && (src_next != dst_addr);
            end
            if (type_done) begin
                type_length_valid <= type_length_ok(tl_next);
            end
            if (terminate) begin
                packet_size_valid <= size_ok;
            end
        end
    end

    // Count frames whose header flags and final size are all good; wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_packet_counter <= '0;
        end else if (terminate && size_ok && preamble_valid && dst_addr_valid &&
                     src_addr_valid && type_length_valid) begin
            valid_packet_counter <= valid_packet_counter + 4'd1;
        end
    end

    epd_size_counter u_size (
        .clock    (clock),
        .reset    (reset),
        .clear    (pre_start),
        .inc      (count_byte),
        .in_range (size_ok)
    );

endmodule

// File: tb/tb_epd.sv
// Testbench for epd: directed frames from the test plan plus randomized
// frames, all checked byte-by-byte against a queue-based frame model.
module tb_epd;

`ifdef EPD_JUMBO_EN
    localparam int MAX_SZ = 9018;
    localparam int SAT_SZ = 16383;
`else
    localparam int MAX_SZ = 1518;
    localparam int SAT_SZ = 2047;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       control;
    logic       preamble_valid;
    logic       dst_addr_valid;
    logic       src_addr_valid;
    logic       type_length_valid;
    logic       packet_size_valid;
    logic [3:0] valid_packet_counter;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the current frame attempt and the flags
    logic [7:0] frm[$];
    bit m_active;
    bit m_pre, m_dst, m_src, m_type, m_size;
    int m_cnt;

    epd dut (
        .clock                (clock),
        .reset                (reset),
        .data                 (data),
        .control              (control),
        .preamble_valid       (preamble_valid),
        .dst_addr_valid       (dst_addr_valid),
        .src_addr_valid       (src_addr_valid),
        .type_length_valid    (type_length_valid),
        .packet_size_valid    (packet_size_valid),
        .valid_packet_counter (valid_packet_counter)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pre"},  int'(preamble_valid),       int'(m_pre));
        check({tag, ".dst"},  int'(dst_addr_valid),       int'(m_dst));
        check({tag, ".src"},  int'(src_addr_valid),       int'(m_src));
        check({tag, ".type"}, int'(type_length_valid),    int'(m_type));
        check({tag, ".size"}, int'(packet_size_valid),    int'(m_size));
        check({tag, ".cnt"},  int'(valid_packet_counter), m_cnt);
    endtask

    task automatic model_reset();
        frm.delete();
        m_active = 0;
        m_pre = 0; m_dst = 0; m_src = 0; m_type = 0; m_size = 0;
        m_cnt = 0;
    endtask

    // Apply one sampled byte to the model. Frame layout by byte position:
    // 0..6 preamble, 7 SFD, 8..13 dst, 14..19 src, 20..21 type, then payload.
    task automatic model_step(input logic [7:0] d, input logic c);
        int n;
        int sz;
        logic [47:0] da, sa;
        if (!m_active) begin
            if (!c && d == 8'h55) begin
                m_active = 1;
                frm.delete();
                frm.push_back(d);
                m_pre = 0; m_dst = 0; m_src = 0; m_type = 0; m_size = 0;
            end
        end else if (c) begin
            n = frm.size();
            if (n >= 22) begin
                sz = n - 8;
                if (sz > SAT_SZ) sz = SAT_SZ;
                m_size = (sz >= 64) && (sz <= MAX_SZ);
                if (m_pre && m_dst && m_src && m_type && m_size) m_cnt = (m_cnt + 1) % 16;
            end else begin
                m_size = 0;
            end
            m_active = 0;
        end else begin
            frm.push_back(d);
            n = frm.size();
            if (n <= 7) begin
                if (d != 8'h55) m_active = 0;
            end else if (n == 8) begin
                if (d == 8'hD5) m_pre = 1;
                else m_active = 0;
            end else if (n == 14) begin
                da = '0;
                for (int i = 8; i < 14; i++) da = {da[39:0], frm[i]};
                m_dst = (da != 0);
            end else if (n == 20) begin
                da = '0;
                sa = '0;
                for (int i = 8; i < 14; i++) da = {da[39:0], frm[i]};
                for (int i = 14; i < 20; i++) sa = {sa[39:0], frm[i]};
                m_src = (sa != 0) && (sa != da);
            end else if (n == 22) begin
                m_type = ({frm[20], frm[21]} <= 16'd1500) || ({frm[20], frm[21]} >= 16'h0600);
            end
        end
    endtask

    // Driver: compare state from previous bytes, then present the next byte
    task automatic send_byte(input logic [7:0] d, input logic c);
        @(negedge clock);
        compare_all("stream");
        data = d;
        control = c;
        @(posedge clock);
        model_step(d, c);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        control = 1'b1;
        data = 8'h07;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_ifg(input int n, input logic c);
        for (int i = 0; i < n; i++) send_byte(c ? 8'h07 : 8'h00, c);
    endtask

    // Build a frame and send the first 'cut' bytes, then one end byte
    // (control=1 terminator when term=1, else data 0x07 with control=0)
    task automatic send_frame(input int pre_n, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] tl, input int plen, input int cut,
                              input bit term, input bit no55);
        logic [7:0] q[$];
        logic [7:0] b;
        for (int i = 0; i < pre_n; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) q.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(src[i*8 +: 8]);
        q.push_back(tl[15:8]);
        q.push_back(tl[7:0]);
        for (int i = 0; i < plen; i++) begin
            b = no55 ? 8'($urandom_range(0, 8'h54)) : 8'($urandom_range(0, 255));
            q.push_back(b);
        end
        for (int i = 0; i < q.size() && i < cut; i++) send_byte(q[i], 1'b0);
        send_byte(8'h07, term ? 1'b1 : 1'b0);
    endtask

    localparam logic [47:0] DST_A = 48'h010203040506;
    localparam logic [47:0] SRC_A = 48'hFFFEFDFCFBFA;

    logic [15:0] type_tbl[7] = '{16'h0800, 16'h05DC, 16'h05DD, 16'h0600, 16'h05FF, 16'h0000, 16'hFFFF};

    initial begin
        logic [47:0] rd, rs;
        int sel;
        reset = 1'b0;
        control = 1'b1;
        data = 8'h07;
        model_reset();
        do_reset();

        // Basic 64-byte frame: all flags, counter 0 -> 1
        send_ifg(2, 1'b1);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("basic.cnt", int'(valid_packet_counter), 1);
        check("basic.size", int'(packet_size_valid), 1);

        // Three frames with 1 and 3 IFG bytes between them
        do_reset();
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(1, 1'b1);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(3, 1'b1);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("three.cnt", int'(valid_packet_counter), 3);

        // Back-to-back: terminator immediately followed by a new preamble
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("b2b.cnt", int'(valid_packet_counter), 5);

        // Control held 0 throughout: the first frame never ends
        do_reset();
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 0, 0);
        send_ifg(1, 1'b0);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 0, 0);
        send_ifg(3, 1'b0);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 0, 0);
        send_ifg(1, 1'b0);
        check("held0.pre", int'(preamble_valid), 1);
        check("held0.type", int'(type_length_valid), 1);
        check("held0.size", int'(packet_size_valid), 0);
        check("held0.cnt", int'(valid_packet_counter), 0);

        // Short preamble: 6x55 then D5
        do_reset();
        send_frame(6, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 1);
        send_ifg(1, 1'b1);
        check("shortpre.pre", int'(preamble_valid), 0);
        check("shortpre.cnt", int'(valid_packet_counter), 0);

        // Long preamble: 8x55 then D5
        send_frame(8, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 1);
        send_ifg(1, 1'b1);
        check("longpre.cnt", int'(valid_packet_counter), 0);

        // Undersized frame (54 bytes)
        send_frame(7, DST_A, SRC_A, 16'h0800, 40, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("small.size", int'(packet_size_valid), 0);
        check("small.cnt", int'(valid_packet_counter), 0);

        // Size boundaries: 63 bad, 64 good, MAX good, MAX+1 bad
        send_frame(7, DST_A, SRC_A, 16'h0800, 49, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("sz63.size", int'(packet_size_valid), 0);
        send_frame(7, DST_A, SRC_A, 16'h0800, MAX_SZ - 14, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("szmax.size", int'(packet_size_valid), 1);
        send_frame(7, DST_A, SRC_A, 16'h0800, MAX_SZ - 13, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("szmax1.size", int'(packet_size_valid), 0);
        check("sz.cnt", int'(valid_packet_counter), 1);

        // Reset mid-DST with counter at 2, then one good frame
        do_reset();
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clock);
        check("middst.cnt_before", int'(valid_packet_counter), 2);
        do_reset();
        send_frame(7, DST_A, SRC_A, 16'h0800, 50, 9999, 1, 0);
        send_ifg(1, 1'b1);
        check("afterrst.cnt", int'(valid_packet_counter), 1);

        // Randomized frames: bad addresses, type boundaries, aborts, odd preambles
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 9);
            rd = (sel == 0) ? 48'd0 : {16'($urandom), 32'($urandom)};
            sel = $urandom_range(0, 9);
            rs = (sel == 0) ? 48'd0 : (sel == 1) ? rd : {16'($urandom), 32'($urandom)};
            send_frame((($urandom_range(0, 9) == 0) ? 6 : 7), rd, rs,
                       type_tbl[$urandom_range(0, 6)], $urandom_range(30, 80),
                       (($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : 9999),
                       ($urandom_range(0, 9) != 0), 0);
            send_ifg($urandom_range(0, 3), 1'b1);
        end

        @(negedge clock);
        compare_all("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
